// File: rtl/count_seq_monitor_pkg.sv
// count_seq_monitor_pkg: shared state encoding, default widths and count limit
//   for the counter-sequence monitor. No ports.
package count_seq_monitor_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2,
        FAULT   = 2'd3
    } state_t;
    localparam int DEF_WIDTH    = 4;
    localparam int DEF_WRAP_W   = 8;
    localparam int DEF_ERR_W    = 4;
    localparam int DEF_LOCK_CNT = 2;
    localparam int CNT_MAX      = 2 ** DEF_WIDTH - 1;
endpackage

// File: rtl/count_seq_monitor_if.sv
// count_seq_monitor_if: bundle between a count source and the sequence monitor.
//   master drives count_in/count_valid/clear_fault and observes the status;
//   slave (the monitor) samples the inputs and drives locked/fault/seq_err/
//   wrap_pulse/wrap_count/err_count.
interface count_seq_monitor_if
    import count_seq_monitor_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int WRAP_W = DEF_WRAP_W,
    parameter int ERR_W  = DEF_ERR_W
);
    logic [WIDTH-1:0]  count_in;
    logic              count_valid;
    logic              clear_fault;
    logic              locked;
    logic              fault;
    logic              seq_err;
    logic              wrap_pulse;
    logic [WRAP_W-1:0] wrap_count;
    logic [ERR_W-1:0]  err_count;
    modport master (
        output count_in, count_valid, clear_fault,
        input  locked, fault, seq_err, wrap_pulse, wrap_count, err_count
    );
    modport slave (
        input  count_in, count_valid, clear_fault,
        output locked, fault, seq_err, wrap_pulse, wrap_count, err_count
    );
endinterface

// File: rtl/count_seq_monitor_sat_counter.sv
// sat_counter: saturating event tally; clr wins over inc.
//   clock, reset : clock and sync active-high reset
//   i_inc        : count one event (ignored once all-ones)
//   i_clr        : synchronous clear
//   o_cnt        : current tally
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         i_inc,
    input  logic         i_clr,
    output logic [W-1:0] o_cnt
);
    logic [W-1:0] r_cnt;
    always_ff @(posedge clock) begin
        if (reset) r_cnt <= '0;
        else       r_cnt <= i_clr ? '0 : (i_inc && !(&r_cnt)) ? r_cnt + 1'b1 : r_cnt;
    end
    assign o_cnt = r_cnt;
endmodule

// File: rtl/count_seq_monitor.sv
// count_seq_monitor: checks that a sampled count advances by +1 modulo 2^WIDTH.
//   clock, reset : clock and sync active-high reset
//   bus (slave)  : count_in/count_valid/clear_fault in;
//                  locked/fault/seq_err/wrap_pulse/wrap_count/err_count out
module count_seq_monitor
    import count_seq_monitor_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int WRAP_W   = DEF_WRAP_W,
    parameter int ERR_W    = DEF_ERR_W,
    parameter int LOCK_CNT = DEF_LOCK_CNT
) (
    input logic clock,
    input logic reset,
    count_seq_monitor_if.slave bus
);
    localparam int SW = $clog2(LOCK_CNT + 1);
    state_t           r_state;
    logic [WIDTH-1:0] r_prev;
    logic [SW-1:0]    r_streak;
    logic             r_locked, r_fault, r_seq_err, r_wrap;
    logic             w_match, w_err, w_wrap;
    assign w_match = bus.count_in == WIDTH'(r_prev + 1'b1);
    // clear_fault suppresses any error report in its cycle
    assign w_err  = bus.count_valid && !bus.clear_fault && !w_match &&
                    (r_state == LOCKED || r_state == FAULT);
    assign w_wrap = bus.count_valid && r_state == LOCKED && w_match && (&r_prev);
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state   <= IDLE;
            r_prev    <= '0;
            r_streak  <= '0;
            r_locked  <= 1'b0;
            r_fault   <= 1'b0;
            r_seq_err <= 1'b0;
            r_wrap    <= 1'b0;
        end else begin
            r_seq_err <= w_err;
            r_wrap    <= w_wrap;
            if (bus.count_valid) r_prev <= bus.count_in;
            if (bus.clear_fault && r_state == FAULT) begin
                r_state  <= ACQUIRE;
                r_fault  <= 1'b0;
                r_streak <= '0;
            end else if (bus.count_valid) begin
                case (r_state)
                    IDLE: begin
                        r_state  <= ACQUIRE;
                        r_streak <= '0;
                    end
                    ACQUIRE: begin
                        if (!w_match) r_streak <= '0;
                        else if (r_streak == SW'(LOCK_CNT - 1)) begin
                            r_state  <= LOCKED;
                            r_locked <= 1'b1;
                            r_streak <= '0;
                        end else r_streak <= r_streak + 1'b1;
                    end
                    LOCKED: begin
                        if (!w_match) begin
                            r_state  <= FAULT;
                            r_locked <= 1'b0;
                            r_fault  <= 1'b1;
                        end
                    end
                    FAULT: ;
                endcase
            end
        end
    end
    assign bus.locked     = r_locked;
    assign bus.fault      = r_fault;
    assign bus.seq_err    = r_seq_err;
    assign bus.wrap_pulse = r_wrap;
    sat_counter #(.W(WRAP_W)) u_wrap_cnt (
        .clock (clock),
        .reset (reset),
        .i_inc (w_wrap),
        .i_clr (1'b0),
        .o_cnt (bus.wrap_count)
    );
    sat_counter #(.W(ERR_W)) u_err_cnt (
        .clock (clock),
        .reset (reset),
        .i_inc (w_err),
        .i_clr (bus.clear_fault),
        .o_cnt (bus.err_count)
    );
endmodule

// File: tb/tb_count_seq_monitor.sv
// tb_count_seq_monitor: directed plus randomized check of two monitors
//   (default widths and WRAP_W=2) against a behavioural model.
module tb_count_seq_monitor;
    import count_seq_monitor_pkg::*;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;
    always #5 clock = ~clock;
    count_seq_monitor_if #(.WIDTH(4), .WRAP_W(8), .ERR_W(4)) bus_a ();
    count_seq_monitor_if #(.WIDTH(4), .WRAP_W(2), .ERR_W(4)) bus_b ();
    count_seq_monitor #(.WIDTH(4), .WRAP_W(8), .ERR_W(4), .LOCK_CNT(2)) dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (bus_a)
    );
    count_seq_monitor #(.WIDTH(4), .WRAP_W(2), .ERR_W(4), .LOCK_CNT(2)) dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (bus_b)
    );
    // behavioural model: plain flags and counters derived from the rules
    bit m_started, m_locked, m_fault, m_se, m_wp;
    int m_streak, m_prev, m_wraps, m_errs;
    function automatic int sat(input int x, input int mx);
        return x > mx ? mx : x;
    endfunction
    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic model(input bit rst, input bit v, input int cin, input bit clr);
        bit ok;
        m_se = 0;
        m_wp = 0;
        if (rst) begin
            {m_started, m_locked, m_fault} = '0;
            m_streak = 0; m_prev = 0; m_wraps = 0; m_errs = 0;
            return;
        end
        ok = cin == (m_prev + 1) % (CNT_MAX + 1);
        if (clr) m_errs = 0;
        if (clr && m_fault) begin
            m_fault = 0;
            m_streak = 0;
        end else if (v) begin
            if (!m_started) begin
                m_started = 1;
                m_streak = 0;
            end else if (m_fault) begin
                if (!ok && !clr) begin m_se = 1; m_errs++; end
            end else if (m_locked) begin
                if (ok) begin
                    if (m_prev == CNT_MAX) begin m_wp = 1; m_wraps++; end
                end else begin
                    m_locked = 0;
                    m_fault = 1;
                    if (!clr) begin m_se = 1; m_errs++; end
                end
            end else begin
                m_streak = ok ? m_streak + 1 : 0;
                if (m_streak == 2) begin m_locked = 1; m_streak = 0; end
            end
        end
        if (v) m_prev = cin;
    endtask
    task automatic step(input bit rst, input bit v, input int cin, input bit clr);
        reset = rst;
        bus_a.count_valid = v; bus_a.count_in = 4'(cin); bus_a.clear_fault = clr;
        bus_b.count_valid = v; bus_b.count_in = 4'(cin); bus_b.clear_fault = clr;
        @(posedge clock);
        model(rst, v, cin, clr);
        #1;
        chk("locked",     int'(bus_a.locked),     int'(m_locked));
        chk("fault",      int'(bus_a.fault),      int'(m_fault));
        chk("seq_err",    int'(bus_a.seq_err),    int'(m_se));
        chk("wrap_pulse", int'(bus_a.wrap_pulse), int'(m_wp));
        chk("wrap_count", int'(bus_a.wrap_count), sat(m_wraps, 255));
        chk("err_count",  int'(bus_a.err_count),  sat(m_errs, 15));
        chk("exclusive",  int'(bus_a.locked & bus_a.fault), 0);
        chk("b_locked",   int'(bus_b.locked),     int'(m_locked));
        chk("b_wrap_cnt", int'(bus_b.wrap_count), sat(m_wraps, 3));
    endtask
    task automatic ramp(input int n);
        for (int i = 0; i < n; i++) step(0, 1, (m_prev + 1) % 16, 0);
    endtask
    initial begin
        int cin;
        bit v, clr, rst;
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("rst_wrap", int'(bus_a.wrap_count), 0);
        // plain ramp from zero: lock on the edge sampling 2
        step(0, 1, 0, 0);
        step(0, 1, 1, 0);
        chk("no_lock_at_1", int'(bus_a.locked), 0);
        step(0, 1, 2, 0);
        chk("lock_at_2", int'(bus_a.locked), 1);
        // upstream held in reset: repeated zeros tolerated
        step(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 0, 0);
        chk("hold_no_err", int'(bus_a.err_count), 0);
        step(0, 1, 1, 0);
        chk("hold_not_yet", int'(bus_a.locked), 0);
        step(0, 1, 2, 0);
        chk("hold_lock", int'(bus_a.locked), 1);
        // three full wraps, ending after the third 15->0
        ramp(13 + 16 + 16 + 1);
        chk("wraps3", int'(bus_a.wrap_count), 3);
        chk("wraps3_b", int'(bus_b.wrap_count), 3);
        // 5 is in sequence, 9 breaks it
        ramp(4);
        step(0, 1, 5, 0);
        step(0, 1, 9, 0);
        chk("brk_seq_err", int'(bus_a.seq_err), 1);
        chk("brk_fault", int'(bus_a.fault), 1);
        chk("brk_err_cnt", int'(bus_a.err_count), 1);
        step(0, 1, 10, 0);
        step(0, 1, 11, 0);
        chk("fault_sticky", int'(bus_a.fault), 1);
        chk("pulse_once", int'(bus_a.seq_err), 0);
        // clear together with a mismatching sample
        step(0, 1, 3, 1);
        chk("clr_no_err", int'(bus_a.seq_err), 0);
        chk("clr_err_cnt", int'(bus_a.err_count), 0);
        chk("clr_fault", int'(bus_a.fault), 0);
        step(0, 1, 4, 0);
        step(0, 1, 5, 0);
        chk("relock", int'(bus_a.locked), 1);
        // two more wraps: narrow tally saturates at 3
        ramp(10 + 16 + 1);
        chk("wraps5_a", int'(bus_a.wrap_count), 5);
        chk("wraps5_b", int'(bus_b.wrap_count), 3);
        // gaps never change anything, then reset mid-lock
        step(0, 0, 9, 0);
        step(0, 0, 3, 0);
        chk("gap_locked", int'(bus_a.locked), 1);
        step(1, 1, 7, 1);
        chk("rst_all", int'({bus_a.locked, bus_a.fault, bus_a.seq_err, bus_a.wrap_pulse,
                             bus_a.wrap_count, bus_a.err_count}), 0);
        // randomized phase
        for (int i = 0; i < 3000; i++) begin
            rst = $urandom_range(0, 399) == 0;
            v   = $urandom_range(0, 7) != 0;
            cin = $urandom_range(0, 24) == 0 ? int'($urandom_range(0, 15)) : (m_prev + 1) % 16;
            clr = !m_locked && $urandom_range(0, 9) == 0;
            step(rst, v, cin, clr);
        end
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
